// File: rtl/loa_lock_pkg.sv
// Shared types for the key-locked lower-part-OR adder.
// Holds the lock FSM states and the key width helper.
package loa_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED,
    ACTIVE,
    DRAIN
  } lock_state_e;

  function automatic int key_w(input int width, input int lower);
    return width - lower + 1;
  endfunction

endpackage

// File: rtl/loa_lock_keyreg.sv
// Serial key shadow register, bit counter and lock FSM.
// Swaps in a new key only once the datapath has drained.
module loa_lock_keyreg
  import loa_lock_pkg::*;
#(
  parameter int KEY_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_shift,
  input  logic             key_bit,
  input  logic             key_commit,
  input  logic             pipe_empty,
  output logic [KEY_W-1:0] active_key,
  output lock_state_e      state,
  output logic             key_loaded,
  output logic             key_err
);

  localparam int CW = $clog2(KEY_W + 1);
  localparam logic [CW-1:0] FULL = CW'(KEY_W);

  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] shadow_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             full;

  // A shift in the same cycle lands before the commit is judged.
  always_comb begin
    shadow_nxt = shadow;
    cnt_nxt    = cnt;
    if (key_shift) begin
      shadow_nxt = {key_bit, shadow[KEY_W-1:1]};
      if (cnt != FULL) cnt_nxt = cnt + 1'b1;
    end
    full = (cnt_nxt == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOCKED;
      shadow     <= '0;
      cnt        <= '0;
      active_key <= '0;
      key_loaded <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      shadow  <= shadow_nxt;
      cnt     <= cnt_nxt;
      key_err <= 1'b0;
      unique case (state)
        LOCKED: begin
          if (key_commit) begin
            if (full) begin
              active_key <= shadow_nxt;
              cnt        <= '0;
              state      <= ACTIVE;
              key_loaded <= 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (key_commit) begin
            if (full) state <= DRAIN;
            else key_err <= 1'b1;
          end
        end
        DRAIN: begin
          if (key_commit) key_err <= 1'b1;
          if (pipe_empty) begin
            active_key <= shadow_nxt;
            cnt        <= '0;
            state      <= ACTIVE;
          end
        end
        default: begin
          state      <= LOCKED;
          key_loaded <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/locked_loa_adder_pipe.sv
// Two-stage lower-part-OR approximate adder whose upper carry
// chain is obfuscated by a serially loaded key.
module locked_loa_adder_pipe
  import loa_lock_pkg::*;
#(
  parameter int                   WIDTH    = 32,
  parameter int                   LOWER    = 8,
  parameter logic [WIDTH-LOWER:0] KEY_MASK = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
  input  logic             key_shift_i,
  input  logic             key_bit_i,
  input  logic             key_commit_i,
  output logic             key_loaded_o,
  output logic             key_err_o
);

  localparam int KEY_W = key_w(WIDTH, LOWER);
  localparam int UW    = WIDTH - LOWER;

  logic [KEY_W-1:0] active_key;
  logic [KEY_W-1:0] k;
  lock_state_e      state;

  logic             s1_valid;
  logic [UW-1:0]    s1_a;
  logic [UW-1:0]    s1_b;
  logic [LOWER-1:0] s1_lo;
  logic             s1_cin;
  logic             s2_valid;
  logic [WIDTH:0]   s2_result;

  logic             s2_can;
  logic             accept;
  logic [UW-1:0]    hi;
  logic             c;
  logic [WIDTH:0]   sum;

  loa_lock_keyreg #(
    .KEY_W(KEY_W)
  ) u_keyreg (
    .clk       (clk_i),
    .rst       (rst_i),
    .key_shift (key_shift_i),
    .key_bit   (key_bit_i),
    .key_commit(key_commit_i),
    .pipe_empty(!s1_valid && !s2_valid),
    .active_key(active_key),
    .state     (state),
    .key_loaded(key_loaded_o),
    .key_err   (key_err_o)
  );

  assign s2_can     = !s2_valid || out_ready_i;
  assign in_ready_o = (state == ACTIVE) && (!s1_valid || s2_can);
  assign accept     = in_valid_i && in_ready_o;

  // Each carry entering an upper bit, and the carry-out, is keyed.
  always_comb begin
    k = active_key ^ KEY_MASK;
    c = s1_cin ^ k[0];
    hi = '0;
    for (int j = 0; j < UW; j++) begin
      hi[j] = s1_a[j] ^ s1_b[j] ^ c;
      c = ((s1_a[j] & s1_b[j]) | (c & (s1_a[j] ^ s1_b[j]))) ^ k[j+1];
    end
    sum = {c, hi, s1_lo};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_lo     <= '0;
      s1_cin    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
    end else begin
      if (!s1_valid || s2_can) begin
        s1_valid <= accept;
        if (accept) begin
          s1_a   <= add1_i[WIDTH-1:LOWER];
          s1_b   <= add2_i[WIDTH-1:LOWER];
          s1_lo  <= add1_i[LOWER-1:0] | add2_i[LOWER-1:0];
          s1_cin <= add1_i[LOWER-1] & add2_i[LOWER-1];
        end
      end
      if (s2_can) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_result <= sum;
      end
    end
  end

  assign out_valid_o = s2_valid;
  assign result_o    = s2_result;

endmodule
